led_display_frame_arbiter: RTL and testbench

- Arbitrates the single-port frame RAM between two requesters: the display row-fetch path (read, latency-critical) and the CPU/UART pixel writer (write).
- Implements double buffering. The display reads the front bank and the writer fills the back bank.
- Banks swap only on a display frame boundary, so a frame is never shown torn.
- Sits between led_display_ram_control, the writer, and the frame RAM, in the 20 MHz display clock domain.

---
 rtl/led_display_frame_arbiter.sv | 154 +++++++++++++++
 tb/tb_led_display_frame_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_display_frame_arbiter.sv
// Frame RAM arbiter for the LED display: shares one single-port RAM between
// the display row fetch (reads, priority) and the pixel writer (writes),
// with double buffering that swaps banks only on a display frame boundary.
module led_display_frame_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  disp_req_in,
    input  logic [ADDR_WIDTH-1:0] disp_addr_in,
    output logic                  disp_gnt_out,
    output logic [DATA_WIDTH-1:0] disp_rdata_out,
    output logic                  disp_rvalid_out,
    input  logic                  wr_req_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    output logic                  wr_gnt_out,
    input  logic                  swap_req_in,
    input  logic                  frame_start_in,
    output logic                  swap_pending_out,
    output logic                  front_sel_out,
    output logic                  ram_en_out,
    output logic                  ram_we_out,
    output logic [ADDR_WIDTH:0]   ram_addr_out,
    output logic [DATA_WIDTH-1:0] ram_wdata_out,
    input  logic [DATA_WIDTH-1:0] ram_rdata_in
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } swap_state_t;

    swap_state_t               state_q;
    logic                      front_sel_q;
    logic [7:0]                wait_cnt_q, wait_cnt_d;
    logic                      pending;
    logic                      force_wr;
    logic                      disp_gnt;
    logic                      wr_gnt;
    logic                      ram_en_q, ram_we_q;
    logic [ADDR_WIDTH:0]       ram_addr_q;
    logic [DATA_WIDTH-1:0]     ram_wdata_q;
    logic                      rd_issue_q;
    logic                      rvalid_q;

    assign pending = (state_q == S_PENDING);

    // Grant decision: display first unless the writer has waited STARVE_LIMIT
    // cycles; the writer is frozen while a swap waits so the back bank stays
    // complete until it becomes the front.
    always_comb begin
        force_wr = wr_req_in && !pending && (wait_cnt_q == LIMIT);
        disp_gnt = disp_req_in && !force_wr && !reset_in;
        wr_gnt   = wr_req_in && !pending && !disp_gnt && !reset_in;
    end

    // Starvation counter: counts display-blocked writer cycles, saturating.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!wr_req_in || pending || wr_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Swap FSM: the bank toggle waits for a frame boundary so no frame is torn;
    // grants in the toggle cycle still see the old front_sel_q.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= S_IDLE;
            front_sel_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (swap_req_in) begin
                        if (frame_start_in) begin
                            front_sel_q <= ~front_sel_q;
                        end else begin
                            state_q <= S_PENDING;
                        end
                    end
                end
                S_PENDING: begin
                    if (frame_start_in) begin
                        front_sel_q <= ~front_sel_q;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RAM command register: bank bit is fixed at grant time; address and
    // write data hold their last value on idle cycles.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else if (disp_gnt) begin
            ram_en_q   <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= {front_sel_q, disp_addr_in};
        end else if (wr_gnt) begin
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= {~front_sel_q, wr_addr_in};
            ram_wdata_q <= wr_data_in;
        end else begin
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
        end
    end

    // Read-return pipeline: issue during N+1, RAM data valid during N+2.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rd_issue_q <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            rd_issue_q <= disp_gnt;
            rvalid_q   <= rd_issue_q;
        end
    end

    assign disp_gnt_out     = disp_gnt;
    assign wr_gnt_out       = wr_gnt;
    assign disp_rvalid_out  = rvalid_q;
    assign disp_rdata_out   = rvalid_q ? ram_rdata_in : '0;
    assign swap_pending_out = pending;
    assign front_sel_out    = front_sel_q;
    assign ram_en_out       = ram_en_q;
    assign ram_we_out       = ram_we_q;
    assign ram_addr_out     = ram_addr_q;
    assign ram_wdata_out    = ram_wdata_q;

endmodule

// File: tb/tb_led_display_frame_arbiter.sv
// Testbench for led_display_frame_arbiter with a 1-cycle synchronous RAM model.
module tb_led_display_frame_arbiter;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        disp_req_in;
    logic [10:0] disp_addr_in;
    logic        disp_gnt_out;
    logic [31:0] disp_rdata_out;
    logic        disp_rvalid_out;
    logic        wr_req_in;
    logic [10:0] wr_addr_in;
    logic [31:0] wr_data_in;
    logic        wr_gnt_out;
    logic        swap_req_in;
    logic        frame_start_in;
    logic        swap_pending_out;
    logic        front_sel_out;
    logic        ram_en_out;
    logic        ram_we_out;
    logic [11:0] ram_addr_out;
    logic [31:0] ram_wdata_out;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_display_frame_arbiter #(
        .ADDR_WIDTH(11), .DATA_WIDTH(32), .STARVE_LIMIT(8)
    ) dut (
        .clk_in(clk), .reset_in(reset_in),
        .disp_req_in(disp_req_in), .disp_addr_in(disp_addr_in),
        .disp_gnt_out(disp_gnt_out), .disp_rdata_out(disp_rdata_out),
        .disp_rvalid_out(disp_rvalid_out),
        .wr_req_in(wr_req_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .wr_gnt_out(wr_gnt_out),
        .swap_req_in(swap_req_in), .frame_start_in(frame_start_in),
        .swap_pending_out(swap_pending_out), .front_sel_out(front_sel_out),
        .ram_en_out(ram_en_out), .ram_we_out(ram_we_out),
        .ram_addr_out(ram_addr_out), .ram_wdata_out(ram_wdata_out),
        .ram_rdata_in(ram_rdata)
    );

    // RAM model: bank 0 word o holds A5A5_0000|o, bank 1 holds 5A5A_0000|o.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_en_out) begin
            if (ram_we_out) mem[ram_addr_out] = ram_wdata_out;
            else            ram_rdata <= mem[ram_addr_out];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        dreq;
        logic [10:0] daddr;
        logic        wreq;
        logic [10:0] waddr;
        logic [31:0] wdata;
        logic        exp_dg;
        logic        exp_wg;
        logic        exp_en;
        logic        exp_we;
        logic [11:0] exp_addr;
        logic [31:0] exp_wdat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int wr_count;
        logic exp_wg;
        for (int i = 0; i < 4096; i++)
            mem[i] = (i < 2048) ? (32'hA5A5_0000 | i) : (32'h5A5A_0000 | (i - 2048));
        ram_rdata = '0;

        vecs[0] = '{1'b1, 11'h005, 1'b0, 11'h000, 32'h0,       1'b1, 1'b0, 1'b1, 1'b0, 12'h005, 32'h0};
        vecs[1] = '{1'b0, 11'h000, 1'b0, 11'h000, 32'h0,       1'b0, 1'b0, 1'b0, 1'b0, 12'h005, 32'h0};
        vecs[2] = '{1'b0, 11'h000, 1'b1, 11'h010, 32'h123,     1'b0, 1'b1, 1'b1, 1'b1, 12'h810, 32'h123};
        vecs[3] = '{1'b1, 11'h7FF, 1'b1, 11'h020, 32'hDEAD,    1'b1, 1'b0, 1'b1, 1'b0, 12'h7FF, 32'h123};
        vecs[4] = '{1'b0, 11'h000, 1'b1, 11'h020, 32'hDEAD,    1'b0, 1'b1, 1'b1, 1'b1, 12'h820, 32'hDEAD};
        vecs[5] = '{1'b1, 11'h001, 1'b0, 11'h000, 32'h0,       1'b1, 1'b0, 1'b1, 1'b0, 12'h001, 32'hDEAD};

        reset_in = 1'b1;
        disp_req_in = 0; disp_addr_in = '0; wr_req_in = 0; wr_addr_in = '0; wr_data_in = '0;
        swap_req_in = 0; frame_start_in = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ram_en", {31'b0, ram_en_out}, 32'd0);
        chk("rst_ram_we", {31'b0, ram_we_out}, 32'd0);
        chk("rst_ram_addr", {20'b0, ram_addr_out}, 32'd0);
        chk("rst_rvalid", {31'b0, disp_rvalid_out}, 32'd0);
        chk("rst_pending", {31'b0, swap_pending_out}, 32'd0);
        chk("rst_front", {31'b0, front_sel_out}, 32'd0);
        @(negedge clk);
        reset_in = 1'b0;

        // Single display read from bank 0.
        @(negedge clk);
        disp_req_in = 1; disp_addr_in = 11'h005;
        #1 chk("t1_dgnt", {31'b0, disp_gnt_out}, 32'd1);
        chk("t1_wgnt", {31'b0, wr_gnt_out}, 32'd0);
        @(negedge clk);
        disp_req_in = 0;
        #1 chk("t1_en", {31'b0, ram_en_out}, 32'd1);
        chk("t1_addr", {20'b0, ram_addr_out}, 32'h005);
        chk("t1_rvalid_early", {31'b0, disp_rvalid_out}, 32'd0);
        @(negedge clk);
        #1 chk("t1_rvalid", {31'b0, disp_rvalid_out}, 32'd1);
        chk("t1_rdata", disp_rdata_out, 32'hA5A5_0005);
        chk("t1_front", {31'b0, front_sel_out}, 32'd0);

        // Table-driven single-cycle arbitration and RAM command checks.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            disp_req_in = vecs[i].dreq; disp_addr_in = vecs[i].daddr;
            wr_req_in = vecs[i].wreq; wr_addr_in = vecs[i].waddr; wr_data_in = vecs[i].wdata;
            #1 chk($sformatf("v%0d_dgnt", i), {31'b0, disp_gnt_out}, {31'b0, vecs[i].exp_dg});
            chk($sformatf("v%0d_wgnt", i), {31'b0, wr_gnt_out}, {31'b0, vecs[i].exp_wg});
            @(posedge clk);
            #1 chk($sformatf("v%0d_en", i), {31'b0, ram_en_out}, {31'b0, vecs[i].exp_en});
            chk($sformatf("v%0d_we", i), {31'b0, ram_we_out}, {31'b0, vecs[i].exp_we});
            chk($sformatf("v%0d_addr", i), {20'b0, ram_addr_out}, {20'b0, vecs[i].exp_addr});
            chk($sformatf("v%0d_wdata", i), ram_wdata_out, vecs[i].exp_wdat);
        end

        // Starvation: both request continuously, writer wins every 9th cycle.
        wr_count = 0;
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            disp_req_in = 1; disp_addr_in = 11'h002;
            wr_req_in = 1; wr_addr_in = 11'h055; wr_data_in = 32'hBEEF;
            exp_wg = ((k % 9) == 8);
            #1 chk($sformatf("st%0d_wgnt", k), {31'b0, wr_gnt_out}, {31'b0, exp_wg});
            chk($sformatf("st%0d_dgnt", k), {31'b0, disp_gnt_out}, {31'b0, ~exp_wg});
            if (wr_gnt_out) wr_count++;
            @(posedge clk);
            #1 chk($sformatf("st%0d_we", k), {31'b0, ram_we_out}, {31'b0, exp_wg});
            if (exp_wg) chk($sformatf("st%0d_bank", k), {31'b0, ram_addr_out[11]}, 32'd1);
        end
        chk("st_wr_count", wr_count, 32'd3);

        // Writer fills back bank, swap waits 5 cycles for the frame boundary.
        @(negedge clk);
        disp_req_in = 0; wr_req_in = 1; wr_addr_in = 11'h010; wr_data_in = 32'h123;
        #1 chk("t3_wgnt", {31'b0, wr_gnt_out}, 32'd1);
        @(negedge clk);
        wr_req_in = 0; swap_req_in = 1;
        #1 chk("t3_pend0", {31'b0, swap_pending_out}, 32'd0);
        @(negedge clk);
        swap_req_in = 0; wr_req_in = 1; wr_addr_in = 11'h030; wr_data_in = 32'h777;
        for (int j = 1; j <= 5; j++) begin
            if (j == 5) frame_start_in = 1;
            #1 chk($sformatf("t3_pend%0d", j), {31'b0, swap_pending_out}, 32'd1);
            chk($sformatf("t3_wblk%0d", j), {31'b0, wr_gnt_out}, 32'd0);
            @(negedge clk);
        end
        frame_start_in = 0; wr_req_in = 0;
        #1 chk("t3_pend_clr", {31'b0, swap_pending_out}, 32'd0);
        chk("t3_front", {31'b0, front_sel_out}, 32'd1);
        @(negedge clk);
        disp_req_in = 1; disp_addr_in = 11'h010;
        #1 chk("t3_dgnt", {31'b0, disp_gnt_out}, 32'd1);
        @(negedge clk);
        disp_req_in = 0;
        #1 chk("t3_addr", {20'b0, ram_addr_out}, 32'h810);
        @(negedge clk);
        #1 chk("t3_rvalid", {31'b0, disp_rvalid_out}, 32'd1);
        chk("t3_rdata", disp_rdata_out, 32'h123);

        // Simultaneous swap request and frame start from IDLE.
        @(negedge clk);
        swap_req_in = 1; frame_start_in = 1;
        #1 chk("t4_pend_a", {31'b0, swap_pending_out}, 32'd0);
        @(negedge clk);
        swap_req_in = 0; frame_start_in = 0;
        #1 chk("t4_pend_b", {31'b0, swap_pending_out}, 32'd0);
        chk("t4_front", {31'b0, front_sel_out}, 32'd0);
        @(negedge clk);
        #1 chk("t4_pend_c", {31'b0, swap_pending_out}, 32'd0);

        // Display read in the toggle cycle uses the old front bank.
        @(negedge clk);
        swap_req_in = 1;
        @(negedge clk);
        swap_req_in = 0;
        #1 chk("t5_pend", {31'b0, swap_pending_out}, 32'd1);
        @(negedge clk);
        frame_start_in = 1; disp_req_in = 1; disp_addr_in = 11'h003;
        #1 chk("t5_dgnt", {31'b0, disp_gnt_out}, 32'd1);
        @(posedge clk);
        #1 chk("t5_addr", {20'b0, ram_addr_out}, 32'h003);
        chk("t5_front", {31'b0, front_sel_out}, 32'd1);
        @(negedge clk);
        frame_start_in = 0; disp_req_in = 0;
        #1 chk("t5_pend_clr", {31'b0, swap_pending_out}, 32'd0);
        @(negedge clk);
        #1 chk("t5_rvalid", {31'b0, disp_rvalid_out}, 32'd1);
        chk("t5_rdata", disp_rdata_out, 32'hA5A5_0003);

        // Reset right after a display grant drops the in-flight read.
        @(negedge clk);
        disp_req_in = 1; disp_addr_in = 11'h004;
        #1 chk("t6_dgnt", {31'b0, disp_gnt_out}, 32'd1);
        @(negedge clk);
        disp_req_in = 0; reset_in = 1;
        #1 chk("t6_en", {31'b0, ram_en_out}, 32'd0);
        chk("t6_addr", {20'b0, ram_addr_out}, 32'd0);
        chk("t6_wdata", ram_wdata_out, 32'd0);
        chk("t6_rvalid_a", {31'b0, disp_rvalid_out}, 32'd0);
        chk("t6_rdata", disp_rdata_out, 32'd0);
        chk("t6_front", {31'b0, front_sel_out}, 32'd0);
        chk("t6_pend", {31'b0, swap_pending_out}, 32'd0);
        @(negedge clk);
        #1 chk("t6_rvalid_b", {31'b0, disp_rvalid_out}, 32'd0);
        @(negedge clk);
        reset_in = 0;
        #1 chk("t6_rvalid_c", {31'b0, disp_rvalid_out}, 32'd0);
        @(negedge clk);
        #1 chk("t6_rvalid_d", {31'b0, disp_rvalid_out}, 32'd0);
        chk("t6_front_after", {31'b0, front_sel_out}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
